// File: rtl/sgpio_tx.sv
// SFF-8485-style SGPIO transmitter: serializes per-drive ACT/LOC/FLT into CK/LD/DATA frames.
// Optional ACT pulse stretching is enabled by defining SGPIO_ACT_STRETCH_EN.
module sgpio_tx #(
  parameter int unsigned NUM_DRV        = 36,
  parameter int unsigned HALF_DIV       = 125,
  parameter int unsigned STRETCH_FRAMES = 4
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic [NUM_DRV-1:0] DRV_ACT,
  input  logic [NUM_DRV-1:0] DRV_LOC,
  input  logic [NUM_DRV-1:0] DRV_FLT,
  output logic               SGPIO_CK,
  output logic               SGPIO_LD,
  output logic               SGPIO_DATA,
  output logic               FRAME_DONE,
  output logic               BUSY
);

  localparam int unsigned FRAME_BITS = 3 * NUM_DRV;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  if (HALF_DIV < 2 || HALF_DIV > 65535 || STRETCH_FRAMES > 7) begin : g_bad_param
    $error("sgpio_tx: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAME_BITS-1:0]   snap_q, snap_d;
  logic                    ck_q, ck_d;
  logic                    ld_q, ld_d;
  logic                    data_q, data_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [NUM_DRV-1:0]      act_eff_c;
  logic [FRAME_BITS-1:0]   frame_c;
  logic [IDX_W-1:0]        idx_nxt_c;

`ifdef SGPIO_ACT_STRETCH_EN
  localparam logic [2:0] STRETCH_LOAD = 3'(STRETCH_FRAMES);

  logic [NUM_DRV-1:0] act_s1_q, act_s2_q, act_s3_q;
  logic [2:0]         cnt_q [NUM_DRV];
  logic [NUM_DRV-1:0] cnt_nz_c;
  logic               snap_load_c;

  // A snapshot happens on IDLE->SHIFT and on the closing edge of a frame that wraps.
  assign snap_load_c = EN && ((state_q == ST_IDLE) ||
                              (div_q == DIV_LAST && ck_q && idx_q == IDX_LAST));

  always_comb begin
    for (int k = 0; k < NUM_DRV; k++) cnt_nz_c[k] = (cnt_q[k] != 3'd0);
  end

  assign act_eff_c = DRV_ACT | cnt_nz_c;

  // Synchronized rising edge or level at snapshot reloads; each snapshot consumes one frame.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      act_s1_q <= '0;
      act_s2_q <= '0;
      act_s3_q <= '0;
      for (int k = 0; k < NUM_DRV; k++) cnt_q[k] <= 3'd0;
    end else begin
      act_s1_q <= DRV_ACT;
      act_s2_q <= act_s1_q;
      act_s3_q <= act_s2_q;
      for (int k = 0; k < NUM_DRV; k++) begin
        if ((snap_load_c && DRV_ACT[k]) || (act_s2_q[k] && !act_s3_q[k])) begin
          cnt_q[k] <= STRETCH_LOAD;
        end else if (snap_load_c && cnt_nz_c[k]) begin
          cnt_q[k] <= cnt_q[k] - 3'd1;
        end
      end
    end
  end
`else
  assign act_eff_c = DRV_ACT;
`endif

  // Frame image: bit 3k = ACT[k], 3k+1 = LOC[k], 3k+2 = FLT[k].
  always_comb begin
    frame_c = '0;
    for (int k = 0; k < NUM_DRV; k++) begin
      frame_c[3*k +: 3] = {DRV_FLT[k], DRV_LOC[k], act_eff_c[k]};
    end
  end

  assign idx_nxt_c = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ck_d    = ck_q;
    ld_d    = ld_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ck_d   = 1'b0;
        ld_d   = 1'b0;
        data_d = 1'b0;
        if (EN) begin
          state_d = ST_SHIFT;
          snap_d  = frame_c;
          idx_d   = '0;
          div_d   = '0;
          ld_d    = 1'b1;
          data_d  = frame_c[0];
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          ck_d  = ~ck_q;
          // Data only moves on the CK falling edge.
          if (ck_q) begin
            if (idx_q == IDX_LAST) begin
              done_d = 1'b1;
              if (EN) begin
                snap_d = frame_c;
                idx_d  = '0;
                ld_d   = 1'b1;
                data_d = frame_c[0];
              end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
                ld_d    = 1'b0;
                data_d  = 1'b0;
              end
            end else begin
              idx_d  = idx_nxt_c;
              ld_d   = 1'b0;
              data_d = snap_q[idx_nxt_c];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      ck_q    <= 1'b0;
      ld_q    <= 1'b0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ck_q    <= ck_d;
      ld_q    <= ld_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign SGPIO_CK   = ck_q;
  assign SGPIO_LD   = ld_q;
  assign SGPIO_DATA = data_q;
  assign FRAME_DONE = done_q;
  assign BUSY       = busy_q;

endmodule
